alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Multi-cycle 8-bit ALU sequencer: ADD/SUB in one pass, shifts/rotates one bit per cycle.
// Define ALU_SEQ_MUL_EN to build the 8-cycle shift-and-add multiplier for opcode 110.
module alu_op_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        carry,
  output logic        zero,
  output logic        err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;
  localparam logic [2:0] OP_ROR = 3'd5;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] OP_MUL = 3'd6;
`endif

  logic [1:0]  r_state;
  logic [2:0]  r_op;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [7:0]  r_cnt;
  logic [15:0] r_result;
  logic        r_carry;
  logic        r_zero;
  logic        r_err;

  logic [7:0]  w_addend;
  logic [7:0]  w_sum;
  logic        w_cout;
  logic [7:0]  w_shift;
  logic [7:0]  w_cnt_init;
  logic        w_final;
  logic [15:0] w_res_next;
  logic        w_carry_next;
  logic        w_err_next;

`ifdef ALU_SEQ_MUL_EN
  logic [15:0] r_acc;
  logic [8:0]  w_mul_sum;
  logic [15:0] w_acc_next;

  // Upper half accumulates the multiplicand, lower half shifts the multiplier out.
  always_comb begin
    w_mul_sum  = r_acc[0] ? ({1'b0, r_acc[15:8]} + {1'b0, r_a}) : {1'b0, r_acc[15:8]};
    w_acc_next = {w_mul_sum, r_acc[7:1]};
  end
`endif

  // SUB reuses the adder as a + ~b + 1, so carry=1 means no borrow.
  always_comb begin
    logic v_c;
    w_addend = (r_op == OP_SUB) ? ~r_b : r_b;
    v_c      = (r_op == OP_SUB);
    w_sum    = '0;
    for (int i = 0; i < 8; i++) begin
      w_sum[i] = r_a[i] ^ w_addend[i] ^ v_c;
      v_c      = (r_a[i] & w_addend[i]) | (v_c & (r_a[i] ^ w_addend[i]));
    end
    w_cout = v_c;
  end

  always_comb begin
    case (r_op)
      OP_SHL:  w_shift = {r_a[6:0], 1'b0};
      OP_SHR:  w_shift = {1'b0, r_a[7:1]};
      OP_ROL:  w_shift = {r_a[6:0], r_a[7]};
      OP_ROR:  w_shift = {r_a[0], r_a[7:1]};
      default: w_shift = r_a;
    endcase
  end

  always_comb begin
    case (op)
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: w_cnt_init = {5'b00000, b[2:0]};
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:                         w_cnt_init = 8'd8;
`endif
      default:                        w_cnt_init = 8'd1;
    endcase
  end

  // A zero shift amount still spends one EXEC cycle and returns a unchanged.
  always_comb begin
    w_final      = 1'b0;
    w_res_next   = '0;
    w_carry_next = 1'b0;
    w_err_next   = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_final      = 1'b1;
        w_res_next   = {8'h00, w_sum};
        w_carry_next = w_cout;
      end
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
        w_final    = (r_cnt <= 8'd1);
        w_res_next = {8'h00, (r_cnt == 8'd0) ? r_a : w_shift};
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        w_final    = (r_cnt == 8'd1);
        w_res_next = w_acc_next;
      end
`endif
      default: begin
        w_final    = 1'b1;
        w_err_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_acc    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_cnt   <= w_cnt_init;
`ifdef ALU_SEQ_MUL_EN
            r_acc   <= {8'h00, b};
`endif
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_a <= w_shift;
`ifdef ALU_SEQ_MUL_EN
          r_acc <= w_acc_next;
`endif
          if (w_final) begin
            r_cnt    <= '0;
            r_result <= w_res_next;
            r_carry  <= w_carry_next;
            r_err    <= w_err_next;
            r_zero   <= (w_res_next == 16'h0000);
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && rst_n;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign err       = r_err;

endmodule
